// File: rtl/const_mult_sqrt2_seq_ctrl.sv
// Shared shift-add engine computing y = x * COEF / 2^COEF_W (sign-magnitude, truncating)
// for two round-robin requesters, one result per COEF_W+2 cycles at best.
module const_mult_sqrt2_seq_ctrl #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32,
  parameter int COEF_W = 13,
  parameter int COEF   = 5793
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  output logic              res_id,
  input  logic              res_ready,
  output logic              busy
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both high;
  // ready never depends on the same port's data, and res_* hold steady until taken.

  localparam int CNT_W = (COEF_W > 1) ? $clog2(COEF_W) : 1;
  localparam logic [COEF_W-1:0] COEF_BITS = COEF_W'(COEF);

  typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

  state_t            state, state_next;
  logic              last_grant;
  logic              grant;
  logic              accept;
  logic              sign;
  logic [DATA_W-1:0] mag;
  logic [DATA_W-1:0] x_sel;
  logic [DATA_W-1:0] mag_in;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  addend;
  logic [ACC_W-1:0]  acc_sum;
  logic [CNT_W-1:0]  cnt;
  logic              last_bit;
  logic [DATA_W-1:0] quot;

  // Tie goes to the requester that did not win last time.
  assign grant      = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
  assign req0_ready = (state == IDLE) && !grant && req0_valid;
  assign req1_ready = (state == IDLE) &&  grant && req1_valid;
  assign accept     = req0_ready || req1_ready;

  assign x_sel  = grant ? req1_data : req0_data;
  assign mag_in = x_sel[DATA_W-1] ? (~x_sel + DATA_W'(1)) : x_sel;

  assign addend   = COEF_BITS[cnt] ? (ACC_W'(mag) << cnt) : '0;
  assign acc_sum  = acc + addend;
  assign last_bit = (cnt == CNT_W'(COEF_W - 1));
  assign quot     = acc_sum[COEF_W +: DATA_W];

  assign res_valid = (state == OUT);
  assign busy      = (state != IDLE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)    state_next = ACCUM;
      ACCUM:   if (last_bit)  state_next = OUT;
      OUT:     if (res_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      sign       <= 1'b0;
      mag        <= '0;
      acc        <= '0;
      cnt        <= '0;
      res_data   <= '0;
      res_id     <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && accept) begin
        sign       <= x_sel[DATA_W-1];
        mag        <= mag_in;
        res_id     <= grant;
        last_grant <= grant;
        acc        <= '0;
        cnt        <= '0;
      end else if (state == ACCUM) begin
        acc <= acc_sum;
        cnt <= cnt + CNT_W'(1);
        // Final step restores the sign on the truncated magnitude.
        if (last_bit) res_data <= sign ? (~quot + DATA_W'(1)) : quot;
      end
    end
  end

endmodule

// File: tb/tb_const_mult_sqrt2_seq_ctrl.sv
// Bench for const_mult_sqrt2_seq_ctrl: directed literal cases, arbitration, backpressure,
// mid-operation reset and randomized traffic against a cycle-level behavioural model.
module tb_const_mult_sqrt2_seq_ctrl;
  localparam int DATA_W = 16;
  localparam int COEF_W = 13;
  localparam int COEF   = 5793;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req0_valid = 1'b0, req1_valid = 1'b0;
  logic [DATA_W-1:0] req0_data = '0, req1_data = '0;
  logic              req0_ready, req1_ready;
  logic              res_valid, res_id, busy;
  logic [DATA_W-1:0] res_data;
  logic              res_ready = 1'b0;

  const_mult_sqrt2_seq_ctrl #(.DATA_W(DATA_W), .ACC_W(32), .COEF_W(COEF_W), .COEF(COEF)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .res_valid(res_valid), .res_data(res_data), .res_id(res_id), .res_ready(res_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // y = trunc(|x| * COEF / 2^COEF_W) with the sign of x restored
  function automatic int model_mult(input logic [DATA_W-1:0] x);
    int xs, m, y;
    xs = int'($signed(x));
    m  = (xs < 0) ? -xs : xs;
    y  = (m * COEF) / (1 << COEF_W);
    return (xs < 0) ? -y : y;
  endfunction

  // Behavioural model: engine is either free, computing for a fixed number of cycles,
  // or holding a result until taken.
  bit    m_free = 1'b1, m_last = 1'b1, m_out = 1'b0;
  int    m_left = 0, m_data = 0, m_id = 0, acc_cyc = 0, n_acc = 0;
  bit    e_g1, e_r0, e_r1;
  bit    hs0 = 1'b0, hs1 = 1'b0;
  logic [DATA_W:0] exp_q[$];
  int    id_log[$];
  int    hs_log[$];

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      chk("rst_res_valid", int'(res_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_res_data", int'(res_data), 0);
      chk("rst_res_id", int'(res_id), 0);
      m_free = 1'b1; m_last = 1'b1; m_out = 1'b0; m_left = 0;
      hs0 = 1'b0; hs1 = 1'b0;
      exp_q.delete();
    end else begin
      e_g1 = (req0_valid && req1_valid) ? !m_last : req1_valid;
      e_r0 = m_free && req0_valid && !e_g1;
      e_r1 = m_free && req1_valid && e_g1;
      hs0 = req0_valid && req0_ready;
      hs1 = req1_valid && req1_ready;
      chk("req0_ready", int'(req0_ready), int'(e_r0));
      chk("req1_ready", int'(req1_ready), int'(e_r1));
      chk("busy", int'(busy), int'(!m_free));
      chk("res_valid", int'(res_valid), int'(m_out));
      if (m_out) begin
        chk("res_data", int'($signed(res_data)), m_data);
        chk("res_id", int'(res_id), m_id);
      end
      if (m_out) begin
        if (res_ready) begin
          chk("result_owed", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) chk("order", int'({res_id, res_data}), int'(exp_q.pop_front()));
          id_log.push_back(int'(res_id));
          hs_log.push_back(cyc);
          m_out = 1'b0;
          m_free = 1'b1;
        end
      end else if (!m_free) begin
        m_left--;
        if (m_left == 0) m_out = 1'b1;
      end else if (e_r0 || e_r1) begin
        m_id   = int'(e_r1);
        m_data = model_mult(e_r1 ? req1_data : req0_data);
        m_last = e_r1;
        m_free = 1'b0;
        m_left = COEF_W;
        acc_cyc = cyc;
        n_acc++;
        exp_q.push_back({e_r1, DATA_W'(m_data)});
      end
    end
  end

  function automatic logic [DATA_W-1:0] rand_x();
    logic [DATA_W-1:0] corners [4];
    corners = '{16'h8000, 16'h7fff, 16'h0000, 16'hffff};
    if ($urandom_range(0, 15) == 0) return corners[$urandom_range(0, 3)];
    return DATA_W'($urandom);
  endfunction

  // One clock of random driving; a pending (unaccepted) sample may be withdrawn.
  task automatic cycle_drive(input int p0, input int p1, input int pr);
    @(posedge clk); #1;
    if (!req0_valid || hs0) begin
      req0_valid = ($urandom_range(0, 99) < p0);
      req0_data  = rand_x();
    end else if (p0 < 100 && $urandom_range(0, 99) < 5) req0_valid = 1'b0;
    if (!req1_valid || hs1) begin
      req1_valid = ($urandom_range(0, 99) < p1);
      req1_data  = rand_x();
    end else if (p1 < 100 && $urandom_range(0, 99) < 5) req1_valid = 1'b0;
    res_ready = ($urandom_range(0, 99) < pr);
  endtask

  task automatic run_one(input logic [DATA_W-1:0] x, input int exp);
    int n;
    bit ok;
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_data = x; req1_valid = 1'b0; res_ready = 1'b1;
    ok = 1'b0;
    for (n = 0; n < 40 && !ok; n++) begin
      @(negedge clk); #1;
      ok = hs0;
    end
    chk("accept_seen", int'(ok), 1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    ok = 1'b0;
    for (n = 0; n < 40 && !ok; n++) begin
      @(negedge clk); #1;
      ok = res_valid;
    end
    chk("result_seen", int'(ok), 1);
    if (ok) begin
      chk("lit_res_data", int'($signed(res_data)), exp);
      chk("lit_res_id", int'(res_id), 0);
      chk("lit_latency", cyc - acc_cyc, COEF_W + 1);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic wait_idle();
    int n;
    req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b1;
    for (n = 0; n < 40 && busy; n++) begin
      @(posedge clk); #1;
    end
    chk("drain_idle", int'(busy), 0);
  endtask

  initial begin
    int base, n, start;
    logic [DATA_W-1:0] xs [7];
    int ys [7];
    int held_id;

    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;

    // Literal cases pin the model: 5793/8192 truncated, sign restored.
    xs = '{16'd1000, 16'd0, -16'sd1000, 16'd100, 16'd32767, 16'h8000, 16'hffff};
    ys = '{707, 0, -707, 70, 23171, -23172, 0};
    for (int i = 0; i < 7; i++) run_one(xs[i], ys[i]);

    // Both requesters valid continuously after reset: strict alternation, 15-cycle cadence.
    do_reset();
    base = id_log.size();
    for (n = 0; n < 200 && id_log.size() < base + 4; n++) cycle_drive(100, 100, 100);
    chk("alt_count", int'(id_log.size() >= base + 4), 1);
    if (id_log.size() >= base + 4) begin
      for (int i = 0; i < 4; i++) chk("alt_id", id_log[base + i], i % 2);
      for (int i = 0; i < 3; i++) chk("alt_period", hs_log[base + i + 1] - hs_log[base + i], COEF_W + 2);
    end

    // Backpressure: hold the next result (req0's) for 20 cycles, then req1 follows.
    held_id = -1;
    for (n = 0; n < 40 && !res_valid; n++) cycle_drive(100, 100, 0);
    chk("bp_valid", int'(res_valid), 1);
    repeat (20) cycle_drive(100, 100, 0);
    for (n = 0; n < 80 && id_log.size() < base + 6; n++) cycle_drive(100, 100, 100);
    chk("bp_count", int'(id_log.size() >= base + 6), 1);
    if (id_log.size() >= base + 6) begin
      held_id = id_log[base + 4];
      chk("bp_held_id", held_id, 0);
      chk("bp_next_id", id_log[base + 5], 1);
    end

    // Reset in the sixth ACCUM cycle: outputs clear immediately, no stale result later.
    wait_idle();
    cycle_drive(100, 0, 100);
    for (n = 0; n < 10 && !busy; n++) cycle_drive(0, 0, 100);
    repeat (5) cycle_drive(0, 0, 100);
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("arst_res_valid", int'(res_valid), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_res_data", int'(res_data), 0);
    chk("arst_res_id", int'(res_id), 0);
    chk("arst_req0_ready", int'(req0_ready), 0);
    chk("arst_req1_ready", int'(req1_ready), 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    base = id_log.size();
    for (n = 0; n < 60 && id_log.size() < base + 1; n++) cycle_drive(100, 100, 100);
    chk("post_rst_count", int'(id_log.size() >= base + 1), 1);
    if (id_log.size() >= base + 1) chk("post_rst_tie_id", id_log[base], 0);

    // Randomized traffic with random valid/ready, checked cycle by cycle by the model.
    start = n_acc;
    for (n = 0; n < 60000 && n_acc < start + 2500; n++) cycle_drive(60, 60, 75);
    chk("random_samples", int'(n_acc >= start + 2500), 1);

    wait_idle();
    @(negedge clk); #1;
    chk("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
